// File: rtl/vga_scan_driver.sv
// VGA raster scan generator: pixel-rate h/v counters, active-low syncs, blanking,
// a registered colour path that lags DrawX/DrawY by one pixel, and a frame tick.
module vga_scan_driver #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] Red,
    input  logic [7:0] Green,
    input  logic [7:0] Blue,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       frame_tick
);

    localparam int unsigned CW       = 10;
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_FIRST = H_VISIBLE + H_FP;
    localparam int unsigned HS_LAST  = H_VISIBLE + H_FP + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_VISIBLE + V_FP;
    localparam int unsigned VS_LAST  = V_VISIBLE + V_FP + V_SYNC - 1;

    logic          div_q, div_d;
    logic          pix_en;
    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic          h_wrap, v_wrap;
    logic          visible, hs_raw, vs_raw;
    logic          frame_tick_d, frame_tick_q;
    logic [7:0]    r_q, g_q, b_q;
    logic          hs_q, vs_q, blank_n_q;

    // Divider and raster counters; counters only move on the pixel-enable edge.
    always_comb begin
        div_d  = ~div_q;
        pix_en = div_q;
        h_wrap = (h_q == CW'(H_TOTAL - 1));
        v_wrap = (v_q == CW'(V_TOTAL - 1));
        h_d    = h_q;
        v_d    = v_q;
        if (pix_en) begin
            h_d = h_wrap ? '0 : h_q + CW'(1);
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + CW'(1);
            end
        end
    end

    // Raw timing decode of the current counter position.
    always_comb begin
        visible = (h_q < CW'(H_VISIBLE)) && (v_q < CW'(V_VISIBLE));
        hs_raw  = !((h_q >= CW'(HS_FIRST)) && (h_q <= CW'(HS_LAST)));
        vs_raw  = !((v_q >= CW'(VS_FIRST)) && (v_q <= CW'(VS_LAST)));
        // Fires on the half-pixel after the counters land on (0, V_VISIBLE).
        frame_tick_d = !div_q && (h_q == '0) && (v_q == CW'(V_VISIBLE));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_q        <= 1'b0;
            h_q          <= '0;
            v_q          <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            h_q          <= h_d;
            v_q          <= v_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // DAC-side registers: colour, syncs and blank all sampled together.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_q       <= 8'h00;
            g_q       <= 8'h00;
            b_q       <= 8'h00;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else if (pix_en) begin
            r_q       <= visible ? Red   : 8'h00;
            g_q       <= visible ? Green : 8'h00;
            b_q       <= visible ? Blue  : 8'h00;
            hs_q      <= hs_raw;
            vs_q      <= vs_raw;
            blank_n_q <= visible;
        end
    end

    assign DrawX       = h_q;
    assign DrawY       = v_q;
    assign VGA_CLK     = div_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Directed bench for vga_scan_driver on a shrunken raster: 24 px x 13 lines,
// hsync at h 18..21, vsync at v 9..10, so a frame is 624 Clk cycles.
module tb_vga_scan_driver;

    logic       clk;
    logic       rst_n;
    logic [7:0] red, green, blue;
    logic [9:0] draw_x, draw_y;
    logic       vga_clk, vga_hs, vga_vs, vga_blank_n, frame_tick;
    logic [7:0] vga_r, vga_g, vga_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;
    bit mon_en = 1'b0;
    logic hs_prev = 1'b1;
    logic vs_prev = 1'b1;
    int hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$];
    int tick_q[$], tick_x[$], tick_y[$];

    vga_scan_driver #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VISIBLE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) dut (
        .Clk(clk), .Reset_n(rst_n),
        .Red(red), .Green(green), .Blue(blue),
        .DrawX(draw_x), .DrawY(draw_y),
        .VGA_CLK(vga_clk), .VGA_HS(vga_hs), .VGA_VS(vga_vs),
        .VGA_BLANK_N(vga_blank_n),
        .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clk rising edges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Event log of sync edges and frame ticks, indexed by edge count.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (hs_prev && !vga_hs) hs_fall.push_back(cyc);
            if (!hs_prev && vga_hs) hs_rise.push_back(cyc);
            if (vs_prev && !vga_vs) vs_fall.push_back(cyc);
            if (!vs_prev && vga_vs) vs_rise.push_back(cyc);
            if (frame_tick) begin
                tick_q.push_back(cyc);
                tick_x.push_back(int'(draw_x));
                tick_y.push_back(int'(draw_y));
            end
            hs_prev = vga_hs;
            vs_prev = vga_vs;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Wait for a raster position, then two edges so the outputs reflect that pixel.
    task automatic pixel_at(input int x, input int y);
        bit found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (int'(draw_x) == x && int'(draw_y) == y) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val("reach_xy", 32'(found), 32'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_x"},     32'(draw_x),      32'd0);
        check_val({tag, "_y"},     32'(draw_y),      32'd0);
        check_val({tag, "_clk"},   32'(vga_clk),     32'd0);
        check_val({tag, "_hs"},    32'(vga_hs),      32'd1);
        check_val({tag, "_vs"},    32'(vga_vs),      32'd1);
        check_val({tag, "_blank"}, 32'(vga_blank_n), 32'd0);
        check_val({tag, "_rgb"},   {8'h00, vga_r, vga_g, vga_b}, 32'h0);
        check_val({tag, "_tick"},  32'(frame_tick),  32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        red = 8'hFF; green = 8'h00; blue = 8'h80;
        #22;
        check_reset_state("rst");

        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check_val("e1_x",     32'(draw_x),      32'd0);
        check_val("e1_clk",   32'(vga_clk),     32'd1);
        check_val("e1_blank", 32'(vga_blank_n), 32'd0);
        @(negedge clk);
        check_val("e2_x",     32'(draw_x),      32'd1);
        check_val("e2_clk",   32'(vga_clk),     32'd0);
        check_val("e2_r",     32'(vga_r),       32'hFF);
        check_val("e2_g",     32'(vga_g),       32'h00);
        check_val("e2_b",     32'(vga_b),       32'h80);
        check_val("e2_blank", 32'(vga_blank_n), 32'd1);

        red = 8'h12; green = 8'h34; blue = 8'h56;
        pixel_at(5, 3);
        check_val("p5_3_rgb",   {8'h00, vga_r, vga_g, vga_b}, 32'h00123456);
        check_val("p5_3_blank", 32'(vga_blank_n), 32'd1);
        red = 8'hFF; green = 8'hFF; blue = 8'hFF;
        pixel_at(15, 3);
        check_val("p15_3_blank", 32'(vga_blank_n), 32'd1);
        check_val("p15_3_r",     32'(vga_r),       32'hFF);
        pixel_at(16, 3);
        check_val("p16_3_blank", 32'(vga_blank_n), 32'd0);
        check_val("p16_3_rgb",   {8'h00, vga_r, vga_g, vga_b}, 32'h0);
        pixel_at(17, 4);
        check_val("p17_4_hs", 32'(vga_hs), 32'd1);
        pixel_at(18, 4);
        check_val("p18_4_hs", 32'(vga_hs), 32'd0);
        pixel_at(21, 4);
        check_val("p21_4_hs", 32'(vga_hs), 32'd0);
        pixel_at(22, 4);
        check_val("p22_4_hs", 32'(vga_hs), 32'd1);
        pixel_at(5, 8);
        check_val("p5_8_blank", 32'(vga_blank_n), 32'd0);
        check_val("p5_8_rgb",   {8'h00, vga_r, vga_g, vga_b}, 32'h0);
        check_val("p5_8_vs",    32'(vga_vs), 32'd1);
        pixel_at(0, 9);
        check_val("p0_9_vs", 32'(vga_vs), 32'd0);
        pixel_at(23, 10);
        check_val("p23_10_vs", 32'(vga_vs), 32'd0);
        pixel_at(0, 11);
        check_val("p0_11_vs", 32'(vga_vs), 32'd1);

        // Let three frame ticks go by (expected at edges 385, 1009, 1633).
        for (int i = 0; i < 3000 && cyc < 2200; i++) @(negedge clk);
        check_val("run_cyc", 32'(cyc >= 2200), 32'd1);
        check_val("hs_fall0", 32'(q_at(hs_fall, 0)), 32'd38);
        check_val("hs_rise0", 32'(q_at(hs_rise, 0)), 32'd46);
        check_val("hs_fall1", 32'(q_at(hs_fall, 1)), 32'd86);
        check_val("vs_fall0", 32'(q_at(vs_fall, 0)), 32'd434);
        check_val("vs_rise0", 32'(q_at(vs_rise, 0)), 32'd530);
        check_val("vs_fall1", 32'(q_at(vs_fall, 1)), 32'd1058);
        check_val("tick_cnt", 32'(tick_q.size()), 32'd3);
        check_val("tick0", 32'(q_at(tick_q, 0)), 32'd385);
        check_val("tick1", 32'(q_at(tick_q, 1)), 32'd1009);
        check_val("tick2", 32'(q_at(tick_q, 2)), 32'd1633);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("tick%0d_x", i), 32'(q_at(tick_x, i)), 32'd0);
            check_val($sformatf("tick%0d_y", i), 32'(q_at(tick_y, i)), 32'd8);
        end

        // Asynchronous reset mid-frame, asserted between clock edges.
        mon_en = 1'b0;
        pixel_at(10, 5);
        check_val("pre_rst_r",     32'(vga_r),       32'hFF);
        check_val("pre_rst_blank", 32'(vga_blank_n), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("arst");
        repeat (3) @(negedge clk);
        check_reset_state("arst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rel_e1_x", 32'(draw_x), 32'd0);
        check_val("rel_e1_y", 32'(draw_y), 32'd0);
        @(negedge clk);
        check_val("rel_e2_x",     32'(draw_x),      32'd1);
        check_val("rel_e2_y",     32'(draw_y),      32'd0);
        check_val("rel_e2_blank", 32'(vga_blank_n), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_scan_driver.md
VGA_SCAN_DRIVER -- requirements
Module: vga_scan_driver

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48: horizontal front porch, sync and back porch in pixels; H_TOTAL = 800.
REQ-003 The block SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-004 The block SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33: vertical porches and sync in lines; V_TOTAL = 525.
REQ-005 Clk  in  1  system clock; the block's only clock (50 MHz).
REQ-006 Reset_n  in  1  asynchronous, active-low reset.
REQ-007 Red, Green, Blue  in  8 each  pixel colour returned combinationally by the colour mapper for the current DrawX/DrawY.
REQ-008 DrawX, DrawY  out  10 each  coordinate of the pixel being requested from the colour mapper.
REQ-009 VGA_CLK  out  1  pixel clock, Clk/2.
REQ-010 VGA_HS, VGA_VS  out  1 each  horizontal and vertical sync, active low.
REQ-011 VGA_BLANK_N  out  1  high while the output pixel is visible.
REQ-012 VGA_R, VGA_G, VGA_B  out  8 each  registered pixel colour to the DAC.
REQ-013 frame_tick  out  1  single-Clk pulse at the start of vertical blanking, used for game-state updates.

Function
REQ-014 A divider bit SHALL toggle on every Clk edge; pix_en = divider==1; VGA_CLK SHALL equal the divider register.
REQ-015 The horizontal counter h SHALL advance only on Clk edges with pix_en=1, counting 0..H_TOTAL-1 and wrapping to 0.
REQ-016 The vertical counter v SHALL increment only on the pix_en edge where h wraps, counting 0..V_TOTAL-1 and wrapping to 0.
REQ-017 DrawX SHALL equal h and DrawY SHALL equal v at all times, including during blanking.
REQ-018 visible SHALL be (h < H_VISIBLE) && (v < V_VISIBLE).
REQ-019 hs_raw SHALL be low for h in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] = [656,751]; vs_raw SHALL be low for v in [490,491].
REQ-020 On each pix_en edge, VGA_R/G/B SHALL register Red/Green/Blue when visible=1, and 0 otherwise.
REQ-021 On the same pix_en edge, VGA_HS, VGA_VS and VGA_BLANK_N SHALL register hs_raw, vs_raw and visible.
REQ-022 All VGA_* data, sync and blank outputs SHALL therefore lag DrawX/DrawY by exactly one pixel period and SHALL be mutually aligned.
REQ-023 VGA_* outputs SHALL hold their values on Clk edges with pix_en=0.
REQ-024 frame_tick SHALL be registered and high for exactly one Clk cycle: the cycle after the pix_en edge at which (h,v) becomes (0, V_VISIBLE).
REQ-025 Exactly one frame_tick SHALL occur per V_TOTAL*H_TOTAL*2 = 840000 Clk cycles.
REQ-026 Counter comparisons SHALL be unsigned, 10 bits wide; no counter SHALL ever hold a value ≥ its TOTAL.

Reset
REQ-027 While Reset_n=0: divider=0, h=0, v=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0, frame_tick=0.
REQ-028 Reset assertion mid-frame SHALL force the REQ-027 values immediately, without waiting for Clk.
REQ-029 After deassertion, the first pix_en SHALL occur on the second Clk rising edge and scanning SHALL restart from (0,0).
REQ-030 The first frame_tick after reset SHALL appear 2*(480*800)+1 Clk edges after deassertion.

Verification
REQ-031 Reset release, mapper driving 0xFF/0x00/0x80 -> after the second Clk edge, VGA_R=FF, G=00, B=80, BLANK_N=1, DrawX=1.
REQ-032 Run one line -> VGA_HS low for exactly 192 Clk cycles, starting 2 Clk cycles after DrawX reaches 656; period 1600 Clk cycles.
REQ-033 Run one frame -> VGA_VS low for exactly 2*800*2 = 3200 Clk cycles; frame period 840000 Clk cycles.
REQ-034 Mapper constant 0xFF, sample during DrawX=700 or DrawY=500 -> VGA_R/G/B=0 and BLANK_N=0 one pixel later.
REQ-035 Count frame_tick over 3 frames -> exactly 3 pulses, each 1 Clk wide, each coinciding with DrawY=480, DrawX=0.
REQ-036 Assert Reset_n=0 at (h=300, v=200) between Clk edges -> outputs reach REQ-027 values asynchronously; after release, DrawX/DrawY restart at (0,0).
